// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;
    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO. Flush empties it in one cycle; push when full and pop when empty are ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    output T              dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited imem requests,
// buffers in-order responses for decode and discards stale responses after a redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_pc_plus4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         pending_q, pending_d, drop_q, drop_d;
    logic [CW-1:0]         buf_cnt, pc_cnt;
    logic                  buf_full, buf_empty, pc_full, pc_empty;
    fetch_entry_t          buf_din, buf_head;
    logic [ADDR_WIDTH-1:0] pc_head;
    logic [CW:0]           inflight;
    logic                  fire, resp_ok, resp_keep, buf_pop;
    logic                  unused_ok;

    // Credit covers both outstanding requests and buffered words, so the buffer never overflows.
    assign inflight       = {1'b0, pending_q} + {1'b0, buf_cnt};
    assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    assign resp_ok   = imem_resp_valid && (pending_q != '0);
    assign resp_keep = resp_ok && (drop_q == '0) && !redirect_valid;
    assign buf_din   = '{inst: imem_resp_data, pc: pc_head};

    assign inst_valid    = !rst && !buf_empty;
    assign buf_pop       = inst_valid && !stall && !redirect_valid;
    assign instruction   = inst_valid ? buf_head.inst : NOP_INST;
    assign inst_pc       = inst_valid ? buf_head.pc : '0;
    assign inst_pc_plus4 = inst_pc + ADDR_WIDTH'(PC_STEP);

    assign unused_ok = ^{pc_cnt, pc_full, pc_empty, buf_full, redirect_pc[1:0]};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q + CW'(fire) - CW'(resp_ok);
        drop_d     = drop_q - CW'(resp_ok && (drop_q != '0));
        if (redirect_valid) begin
            // Everything still outstanding after this cycle's response is stale.
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            drop_d     = pending_d;
        end else if (fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (resp_keep),
        .din_i   (buf_din),
        .pop_i   (buf_pop),
        .dout_o  (buf_head),
        .count_o (buf_cnt),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Tracks the address of every accepted request until its response returns.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [ADDR_WIDTH-1:0])) u_pcq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (fire),
        .din_i   (imem_req_addr),
        .pop_i   (resp_ok),
        .dout_o  (pc_head),
        .count_o (pc_cnt),
        .full_o  (pc_full),
        .empty_o (pc_empty)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable memory model and a PC scoreboard.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instruction, inst_pc, inst_pc_plus4;
    logic        stall, redirect_valid, inst_valid;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(instruction), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       memq[$];
    logic [31:0] expq[$];
    int          total = 0, bad = 0, cyc = 0, lat = 1, fires = 0;
    int          ff_cyc, fv_cyc;
    logic [31:0] ff_addr, fv_pc, held_pc, held_inst, held_addr;
    bit          arm_redir = 0, redir_fired = 0;
    logic [31:0] arm_pc;
    int          nf;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_instruction"}, instruction, 32'h0000_0013);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_pc_plus4"}, inst_pc_plus4, 32'h4);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        redir_fired = 0;
        if (arm_redir && imem_resp_valid && inst_valid && !stall) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm_redir      = 0;
            redir_fired    = 1;
            #1;
        end
        if (rst) begin
            memq.delete();
            expq.delete();
        end else begin
            if (inst_valid) begin
                if (fv_cyc < 0) begin fv_cyc = cyc; fv_pc = inst_pc; end
                if (expq.size() == 0) chk("sb_spurious", 32'(expq.size()), 32'd1);
                else begin
                    chk("sb_pc", inst_pc, expq[0]);
                    chk("sb_inst", instruction, mdata(expq[0]));
                    chk("sb_plus4", inst_pc_plus4, expq[0] + 32'd4);
                    if (!stall && !redirect_valid) void'(expq.pop_front());
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                memq.push_back('{imem_req_addr, cyc + lat});
                expq.push_back(imem_req_addr);
                if (ff_cyc < 0) begin ff_cyc = cyc; ff_addr = imem_req_addr; end
                fires++;
            end
            if (redirect_valid) expq.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (redir_fired) redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1; imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = '0;
        stall = 0; redirect_valid = 0; redirect_pc = '0; ff_cyc = -1; fv_cyc = -1;
        @(negedge clk);
        #1 chk_reset_outs("rst");
        step(); step();

        // Stream from reset with L=1.
        rst = 0;
        #1;
        chk("t1_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 12; i++) step();
        chk("t1_first_fire", ff_addr, 32'h0);
        chk("t1_latency", 32'(fv_cyc - ff_cyc), 32'd2);
        chk("t1_first_pc", fv_pc, 32'h0);

        // Stall: buffer fills, issue stops, outputs hold.
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        held_pc = inst_pc; held_inst = instruction;
        chk("t2_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_pc", inst_pc, held_pc);
            chk("t2_hold_inst", instruction, held_inst);
        end
        chk("t2_no_req", 32'(imem_req_valid), 32'd0);
        stall = 0;
        for (int i = 0; i < 6; i++) step();

        // Memory not ready: address holds, then fires exactly once.
        imem_req_ready = 0;
        for (int i = 0; i < 3; i++) step();
        #1 held_addr = imem_req_addr;
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_addr_hold", imem_req_addr, held_addr);
            step();
        end
        imem_req_ready = 1;
        nf = fires; ff_cyc = -1;
        step();
        chk("t3_one_fire", 32'(fires - nf), 32'd1);
        chk("t3_fire_addr", ff_addr, held_addr);
        imem_req_ready = 0;
        for (int i = 0; i < 8; i++) step();
        chk("t3_drained_exp", 32'(expq.size()), 32'd0);
        chk("t3_drained_mem", 32'(memq.size()), 32'd0);

        // L=3 redirect with two requests outstanding.
        lat = 3; imem_req_ready = 1;
        for (int i = 0; i < 20 && memq.size() != 2; i++) step();
        chk("t4_pending2", 32'(memq.size()), 32'd2);
        redirect_valid = 1; redirect_pc = 32'h103; ff_cyc = -1;
        #1 chk("t4_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 0;
        fv_cyc = -1;
        #1 chk("t4_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 20; i++) step();
        chk("t4_fire_addr", ff_addr, 32'h100);
        chk("t4_first_pc", fv_pc, 32'h100);

        // Redirect coinciding with a response and a pop.
        lat = 1; arm_pc = 32'h200; arm_redir = 1;
        for (int i = 0; i < 20 && !redir_fired; i++) step();
        chk("t5_armed", 32'(redir_fired), 32'd1);
        #1 chk("t5_flushed", 32'(inst_valid), 32'd0);
        fv_cyc = -1;
        for (int i = 0; i < 8; i++) step();
        chk("t5_first_pc", fv_pc, 32'h200);

        // Reset mid-stream with a full buffer.
        stall = 1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_full", 32'(inst_valid), 32'd1);
        rst = 1;
        step();
        #1 chk_reset_outs("t6");
        rst = 0; stall = 0; ff_cyc = -1;
        #1;
        chk("t6_empty", 32'(inst_valid), 32'd0);
        chk("t6_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("t6_fire_addr", ff_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
